// File: rtl/fiat_25519_mul_pkg.sv
// Shared types and helpers for the fiat_25519 carry-multiply product unit.
// Optional accumulate stage is selected by the FIAT_25519_MUL_ACC_EN macro.
package fiat_25519_mul_pkg;

  // Widest product/result the resize helper handles.
  localparam int unsigned MAX_W = 128;

  // Per-beat tag carried alongside the product through every stage.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  // Full signed product width: signed operand times zero-extended unsigned operand.
  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1 + 1;
  endfunction

  // Sign-extend a pw-bit value held in the low bits of p to MAX_W bits;
  // callers cast the result down to dout width (truncate or sign-extend).
  function automatic logic [MAX_W-1:0] resize_to_dout(input logic [MAX_W-1:0] p,
                                                      input int unsigned pw);
    logic signed [MAX_W-1:0] t;
    t = $signed(p << (MAX_W - pw));
    return t >>> (MAX_W - pw);
  endfunction

endpackage

// File: rtl/fiat_25519_carry_mul_pipe_reg.sv
// ce-gated, asynchronously reset delay line carrying the resized product and its tag.
module fiat_25519_carry_mul_pipe_reg
  import fiat_25519_mul_pkg::*;
#(
  parameter int NUM_STAGE = 3,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DATA_W-1:0] i_data,
  input  tag_t              i_tag,
  output logic [DATA_W-1:0] o_data,
  output tag_t              o_tag
);

  localparam int SW = DATA_W + $bits(tag_t);

  logic [NUM_STAGE*SW-1:0] r_pipe;
  logic [SW-1:0]           w_in;

  assign w_in = {i_tag, i_data};

  if (NUM_STAGE == 1) begin : g_one
    // Single register stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)   r_pipe <= '0;
      else if (ce) r_pipe <= w_in;
    end
  end else begin : g_many
    // Shift the whole tag+data word one stage per enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)   r_pipe <= '0;
      else if (ce) r_pipe <= {r_pipe[(NUM_STAGE-1)*SW-1:0], w_in};
    end
  end

  assign {o_tag, o_data} = r_pipe[NUM_STAGE*SW-1 -: SW];

endmodule

// File: rtl/fiat_25519_carry_mul_mul_su_pipe.sv
// Pipelined signed x unsigned multiplier with ce, valid tracking and an
// optional multiply-accumulate stage enabled by FIAT_25519_MUL_ACC_EN.
module fiat_25519_carry_mul_mul_su_pipe
  import fiat_25519_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld
);

  localparam int PW        = int'(prod_width(din0_WIDTH, din1_WIDTH));
  localparam int unused_id = ID;

  if (NUM_STAGE < 1) begin : g_bad_depth
    $error("NUM_STAGE must be at least 1");
  end

  logic signed [PW-1:0]  w_prod;
  logic [dout_WIDTH-1:0] w_prod_d;
  logic [dout_WIDTH-1:0] w_tail_prod;
  tag_t                  w_in_tag;
  tag_t                  w_tail_tag;

  assign w_prod   = PW'($signed(din0)) * PW'($signed({1'b0, din1}));
  assign w_prod_d = dout_WIDTH'(resize_to_dout(MAX_W'($unsigned(w_prod)), PW));
  assign w_in_tag = '{vld: din_vld, first: acc_first, last: acc_last};

  fiat_25519_carry_mul_pipe_reg #(
    .NUM_STAGE (NUM_STAGE),
    .DATA_W    (dout_WIDTH)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .i_data (w_prod_d),
    .i_tag  (w_in_tag),
    .o_data (w_tail_prod),
    .o_tag  (w_tail_tag)
  );

`ifdef FIAT_25519_MUL_ACC_EN
  logic [dout_WIDTH-1:0] r_acc;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;
  logic [dout_WIDTH-1:0] w_sum;

  assign w_sum = (w_tail_tag.first ? '0 : r_acc) + w_tail_prod;

  // Accumulate valid beats; publish the sum on the closing beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else if (ce) begin
      r_dout_vld <= w_tail_tag.vld & w_tail_tag.last;
      if (w_tail_tag.vld) begin
        r_acc <= w_sum;
        if (w_tail_tag.last) r_dout <= w_sum;
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
`else
  logic [dout_WIDTH-1:0] r_hold;
  logic                  w_unused_tags;

  assign w_unused_tags = w_tail_tag.first ^ w_tail_tag.last;

  // Remember the last valid product so dout holds across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_hold <= '0;
    else if (ce && w_tail_tag.vld)   r_hold <= w_tail_prod;
  end

  // Pipeline tail drives dout directly while valid, else the held value.
  assign dout     = w_tail_tag.vld ? w_tail_prod : r_hold;
  assign dout_vld = w_tail_tag.vld;
`endif

endmodule

// File: tb/tb_fiat_25519_carry_mul_mul_su_pipe.sv
// Self-checking bench for fiat_25519_carry_mul_mul_su_pipe (default parameters).
// Covers both builds; FIAT_25519_MUL_ACC_EN selects the accumulate checks.
module tb_fiat_25519_carry_mul_mul_su_pipe;

  localparam int NS = 3;
`ifdef FIAT_25519_MUL_ACC_EN
  localparam int R = NS + 1;
`else
  localparam int R = NS;
`endif

  logic        clk;
  logic        reset;
  logic        ce;
  logic        din_vld;
  logic [31:0] din0;
  logic [5:0]  din1;
  logic        acc_first;
  logic        acc_last;
  logic [31:0] dout;
  logic        dout_vld;

  fiat_25519_carry_mul_mul_su_pipe #(
    .ID         (1),
    .NUM_STAGE  (NS),
    .din0_WIDTH (32),
    .din1_WIDTH (6),
    .dout_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .din_vld   (din_vld),
    .din0      (din0),
    .din1      (din1),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .dout      (dout),
    .dout_vld  (dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: results scheduled by the enabled-edge count at which they appear.
  int unsigned  en_cnt = 0;
  logic [31:0]  due_val [int unsigned];
  logic [31:0]  m_acc  = '0;
  logic [31:0]  m_hold = '0;
  logic [31:0]  m_dout = '0;
  logic         m_vld  = 1'b0;

  function automatic logic [31:0] prod32(input logic [31:0] a, input logic [5:0] b);
    longint      p;
    logic [63:0] pv;
    p  = longint'($signed(a)) * longint'(b);
    pv = p;
    return pv[31:0];
  endfunction

  task automatic model_clear();
    due_val.delete();
    m_acc  = '0;
    m_hold = '0;
    m_dout = '0;
    m_vld  = 1'b0;
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [5:0] b, input logic f, input logic l);
    logic [31:0] p;
    p = prod32(a, b);
`ifdef FIAT_25519_MUL_ACC_EN
    m_acc = f ? p : m_acc + p;
    if (l) due_val[en_cnt + R - 1] = m_acc;
`else
    due_val[en_cnt + R - 1] = p;
`endif
  endtask

  // Drive one cycle at the negedge, let the edge happen, update the model, return at the next negedge.
  task automatic step(input logic c, input logic v, input logic [31:0] a, input logic [5:0] b,
                      input logic f, input logic l);
    ce = c; din_vld = v; din0 = a; din1 = b; acc_first = f; acc_last = l;
    @(posedge clk);
    if (!reset && c) begin
      en_cnt++;
      if (v) model_beat(a, b, f, l);
    end
    @(negedge clk);
    if (due_val.exists(en_cnt)) begin
      m_vld  = 1'b1;
      m_dout = due_val[en_cnt];
      m_hold = m_dout;
    end else begin
      m_vld  = 1'b0;
      m_dout = m_hold;
    end
  endtask

  task automatic bubble();
    step(1'b1, 1'b0, $urandom, 6'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; din_vld = 1'b1; din0 = 32'd5; din1 = 6'd5;
    acc_first = 1'b1; acc_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout: got=%h want=%h", dout, 32'd0); end
    total++;
    if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got=%b want=0", dout_vld); end
    model_clear();
    reset = 1'b0;
    repeat (R + 1) begin
      bubble();
      total++;
      if (dout_vld !== 1'b0 || dout !== 32'd0) begin
        bad++; $display("FAIL reset_idle: dout=%h vld=%b want dout=0 vld=0", dout, dout_vld);
      end
    end
  endtask

  // Single beats (first=last=1): latency, value and one-cycle pulse.
  task automatic test_multiply();
    logic [31:0] ta [3];
    logic [5:0]  tb [3];
    logic [31:0] te [3];
    ta[0] = 32'hFFFFFFFD; tb[0] = 6'd19; te[0] = 32'hFFFFFFC7;
    ta[1] = 32'h7FFFFFFF; tb[1] = 6'd63; te[1] = 32'h7FFFFFC1;
    ta[2] = 32'd5;        tb[2] = 6'd7;  te[2] = 32'd35;
    for (int k = 0; k < 3; k++) begin
      int          at;
      int          pulses;
      logic [31:0] got;
      at = 0; pulses = 0; got = '0;
      step(1'b1, 1'b1, ta[k], tb[k], 1'b1, 1'b1);
      for (int n = 1; n <= R + 2; n++) begin
        total++;
        if (dout_vld !== m_vld || dout !== m_dout) begin
          bad++; $display("FAIL mul_model[%0d]: dout=%h vld=%b want dout=%h vld=%b", k, dout, dout_vld, m_dout, m_vld);
        end
        if (dout_vld === 1'b1) begin
          pulses++;
          if (at == 0) begin at = n; got = dout; end
        end
        bubble();
      end
      total++;
      if (at != R) begin bad++; $display("FAIL mul_latency[%0d]: got=%0d want=%0d", k, at, R); end
      total++;
      if (got !== te[k]) begin bad++; $display("FAIL mul_value[%0d]: got=%h want=%h", k, got, te[k]); end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL mul_pulses[%0d]: got=%0d want=1", k, pulses); end
      total++;
      if (dout !== te[k]) begin bad++; $display("FAIL mul_hold[%0d]: got=%h want=%h", k, dout, te[k]); end
    end
  endtask

  // Six back-to-back beats with a two-cycle ce stall after the third.
  task automatic test_stall();
    logic        cep [8];
    logic [31:0] a   [6];
    logic [5:0]  b   [6];
    logic [31:0] res [$];
    int          last_at;
    int          bi;
    cep = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin a[i] = $urandom; b[i] = 6'($urandom); end
    bi = 0; last_at = 0;
    for (int n = 1; n <= 8 + R + 2; n++) begin
      if (n <= 8 && cep[n-1]) begin
        step(1'b1, 1'b1, a[bi], b[bi], 1'b1, 1'b1);
        bi++;
      end else if (n <= 8) begin
        step(1'b0, 1'b1, $urandom, 6'($urandom), 1'b1, 1'b1);
      end else begin
        bubble();
      end
      total++;
      if (dout_vld !== m_vld || dout !== m_dout) begin
        bad++; $display("FAIL stall_model[%0d]: dout=%h vld=%b want dout=%h vld=%b", n, dout, dout_vld, m_dout, m_vld);
      end
      if (dout_vld === 1'b1 && ce === 1'b1) begin res.push_back(dout); last_at = n; end
    end
    total++;
    if (res.size() != 6) begin bad++; $display("FAIL stall_count: got=%0d want=6", res.size()); end
    for (int i = 0; i < 6 && i < res.size(); i++) begin
      total++;
      if (res[i] !== prod32(a[i], b[i])) begin
        bad++; $display("FAIL stall_order[%0d]: got=%h want=%h", i, res[i], prod32(a[i], b[i]));
      end
    end
    total++;
    if (last_at != 8 + R - 1) begin bad++; $display("FAIL stall_shift: got=%0d want=%0d", last_at, 8 + R - 1); end
  endtask

`ifdef FIAT_25519_MUL_ACC_EN
  // Three-term column sum: 2*19 + 3*19 - 19 = 76.
  task automatic test_accumulate();
    int          at;
    int          pulses;
    logic [31:0] got;
    at = 0; pulses = 0; got = '0;
    step(1'b1, 1'b1, 32'd2,        6'd19, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'd3,        6'd19, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFFFFFF, 6'd19, 1'b0, 1'b1);
    for (int n = 3; n <= 3 + R + 2; n++) begin
      total++;
      if (dout_vld !== m_vld || dout !== m_dout) begin
        bad++; $display("FAIL acc_model[%0d]: dout=%h vld=%b want dout=%h vld=%b", n, dout, dout_vld, m_dout, m_vld);
      end
      if (dout_vld === 1'b1) begin pulses++; if (at == 0) begin at = n; got = dout; end end
      bubble();
    end
    total++;
    if (got !== 32'h0000004C) begin bad++; $display("FAIL acc_value: got=%h want=%h", got, 32'h4C); end
    total++;
    if (at != 3 + R - 1) begin bad++; $display("FAIL acc_latency: got=%0d want=%0d", at, 3 + R - 1); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL acc_pulses: got=%0d want=1", pulses); end
  endtask
`else
  // Without the accumulator, first/last are ignored: every valid beat yields a result.
  task automatic test_accumulate();
    int pulses;
    pulses = 0;
    step(1'b1, 1'b1, 32'd2,        6'd19, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'd3,        6'd19, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFFFFFF, 6'd19, 1'b0, 1'b1);
    for (int n = 3; n <= 3 + R + 2; n++) begin
      total++;
      if (dout_vld !== m_vld || dout !== m_dout) begin
        bad++; $display("FAIL noacc_model[%0d]: dout=%h vld=%b want dout=%h vld=%b", n, dout, dout_vld, m_dout, m_vld);
      end
      if (dout_vld === 1'b1) pulses++;
      bubble();
    end
    total++;
    if (pulses != 3) begin bad++; $display("FAIL noacc_pulses: got=%0d want=3", pulses); end
    total++;
    if (dout !== 32'hFFFFFFED) begin bad++; $display("FAIL noacc_last: got=%h want=%h", dout, 32'hFFFFFFED); end
  endtask
`endif

  task automatic test_reset_mid();
    int          at;
    int          pulses;
    logic [31:0] got;
    step(1'b1, 1'b1, 32'd7, 6'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'd9, 6'd2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    total++;
    if (dout !== 32'd0) begin bad++; $display("FAIL rmid_dout: got=%h want=%h", dout, 32'd0); end
    total++;
    if (dout_vld !== 1'b0) begin bad++; $display("FAIL rmid_vld: got=%b want=0", dout_vld); end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (R + 2) begin
      bubble();
      if (dout_vld === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL rmid_stale: got=%0d want=0", pulses); end
    at = 0; got = '0;
    step(1'b1, 1'b1, 32'd4, 6'd4, 1'b1, 1'b1);
    for (int n = 1; n <= R + 1; n++) begin
      if (dout_vld === 1'b1 && at == 0) begin at = n; got = dout; end
      bubble();
    end
    total++;
    if (got !== 32'd16 || at != R) begin
      bad++; $display("FAIL rmid_fresh: got=%h at=%0d want=%h at=%0d", got, at, 32'd16, R);
    end
  endtask

  // Random beats, ce and first/last against the model every cycle.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 4) != 0), 1'($urandom), $urandom, 6'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      total++;
      if (dout_vld !== m_vld || dout !== m_dout) begin
        bad++; $display("FAIL random[%0d]: dout=%h vld=%b want dout=%h vld=%b", n, dout, dout_vld, m_dout, m_vld);
      end
    end
  endtask

  initial begin
    reset = 1'b0; ce = 1'b0; din_vld = 1'b0; din0 = '0; din1 = '0;
    acc_first = 1'b0; acc_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_multiply();
    test_stall();
    test_accumulate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
